// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte output bundle of the UART receiver
//
// Signals (driven by the receiver, read by the byte consumer):
//   recv_valid  1-cycle pulse, recv_data holds a new good byte
//   recv_data   last good byte, held until the next good frame
//   frame_err   1-cycle pulse, stop bit sampled low, byte discarded
//   recv_busy   high while a frame is being received
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_if;
    logic       recv_valid;
    logic [7:0] recv_data;
    logic       frame_err;
    logic       recv_busy;

    modport master (
        output recv_valid,
        output recv_data,
        output frame_err,
        output recv_busy
    );

    modport slave (
        input recv_valid,
        input recv_data,
        input frame_err,
        input recv_busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1, LSB first, mid-bit sampling
//
// Parameters:
//   CLK_FRE    system clock frequency in MHz
//   UART_RATE  baud rate in bit/s
// Ports:
//   i_sys_clk  system clock, rising edge
//   i_rst_n    synchronous reset, active-low
//   i_rx_pin   asynchronous serial input, idles high
//   rx_if      received-byte bundle (uart_rx_if.master)
module uart_rx #(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200
) (
    input  logic      i_sys_clk,
    input  logic      i_rst_n,
    input  logic      i_rx_pin,
    uart_rx_if.master rx_if
);
    // One bit lasts RATE_CNT+1 clocks; the start bit is checked HALF_CNT clocks
    // after the detected edge, which puts every later sample at mid-bit.
    localparam int RATE_CNT = (CLK_FRE * 1000000 / UART_RATE) - 1;
    localparam int HALF_CNT = RATE_CNT / 2;
    localparam logic [25:0] RATE_C = 26'(RATE_CNT);
    localparam logic [25:0] HALF_C = 26'(HALF_CNT);

    typedef enum logic [1:0] {
        RX_WAIT,
        RX_START,
        RX_DATA,
        RX_STOP
    } state_t;

    state_t      state;
    logic [1:0]  sync;
    logic        rx_d;
    logic        rx_s;
    logic        fall;
    logic [25:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        recv_valid;
    logic [7:0]  recv_data;
    logic        frame_err;

    assign rx_s = sync[1];
    // Only a genuine high->low transition starts a frame, so a line stuck
    // low after a break never re-triggers reception.
    assign fall = rx_d & ~rx_s;

    assign rx_if.recv_valid = recv_valid;
    assign rx_if.recv_data  = recv_data;
    assign rx_if.frame_err  = frame_err;
    assign rx_if.recv_busy  = (state != RX_WAIT);

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            sync       <= 2'b11;
            rx_d       <= 1'b1;
            state      <= RX_WAIT;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            recv_valid <= 1'b0;
            recv_data  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], i_rx_pin};
            rx_d       <= rx_s;
            recv_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                RX_WAIT: begin
                    if (fall) begin
                        state   <= RX_START;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end

                RX_START: begin
                    if (clk_cnt == HALF_C) begin
                        clk_cnt <= '0;
                        // A line back high at mid start bit was only a glitch.
                        state   <= rx_s ? RX_WAIT : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 26'd1;
                    end
                end

                RX_DATA: begin
                    if (clk_cnt == RATE_C) begin
                        shift[bit_cnt] <= rx_s;
                        clk_cnt        <= '0;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 26'd1;
                    end
                end

                RX_STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch the
                    // next start edge of a back-to-back frame.
                    if (clk_cnt == RATE_C) begin
                        clk_cnt <= '0;
                        state   <= RX_WAIT;
                        if (rx_s) begin
                            recv_data  <= shift;
                            recv_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 26'd1;
                    end
                end

                default: begin
                    sync       <= 2'b11;
                    rx_d       <= 1'b1;
                    state      <= RX_WAIT;
                    clk_cnt    <= '0;
                    bit_cnt    <= '0;
                    shift      <= '0;
                    recv_valid <= 1'b0;
                    recv_data  <= 8'h00;
                    frame_err  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;
    localparam int CLK_FRE   = 1;
    localparam int UART_RATE = 100000;
    // Pin edge to pulse: 3 sync/edge clocks + (HALF_CNT+1) + 9 bits of 10 clocks.
    localparam int LAT       = 3 + 5 + 9 * 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pin   = 1'b1;
    logic rst_q = 1'b0;
    int   cyc   = 0;

    uart_rx_if rif ();

    uart_rx #(
        .CLK_FRE  (CLK_FRE),
        .UART_RATE(UART_RATE)
    ) dut (
        .i_sys_clk(clk),
        .i_rst_n  (rst_n),
        .i_rx_pin (pin),
        .rx_if    (rif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    typedef struct packed {
        logic       err;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       exp_arr [128];
    int         wr_idx     = 0;
    int         rd_idx     = 0;
    logic [7:0] model_last = 8'h00;
    int         n_chk      = 0;
    int         n_pass     = 0;
    int         n_valid    = 0;
    int         n_err      = 0;
    int         low_run    = 0;
    int         max_gap    = 0;
    bit         gap_track  = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic int bit_len(input int mode, input int j);
        if (mode == 1) return (j == 1 || j == 3 || j == 6 || j == 8) ? 11 : 10;
        if (mode == 2) return (j == 2 || j == 4 || j == 6 || j == 9) ? 9 : 10;
        return 10;
    endfunction

    // mode 0: nominal 10-clock bits, 1: stretched to 10.4 avg, 2: shrunk to 9.6 avg
    task automatic send_frame(input logic [7:0] data, input logic stop, input int mode);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        exp_arr[wr_idx].err  = ~stop;
        exp_arr[wr_idx].data = data;
        exp_arr[wr_idx].due  = cyc + LAT;
        wr_idx++;
        for (int j = 0; j < 10; j++) begin
            pin = bits[j];
            repeat (bit_len(mode, j)) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        pin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!rst_q) begin
                chk("rst_valid", rif.recv_valid, 0);
                chk("rst_err", rif.frame_err, 0);
                chk("rst_data", rif.recv_data, 0);
                chk("rst_busy", rif.recv_busy, 0);
                model_last = 8'h00;
                rd_idx     = wr_idx;
                low_run    = 0;
            end else begin
                chk("valid_err_exclusive", rif.recv_valid & rif.frame_err, 0);
                if (rif.recv_valid || rif.frame_err) begin
                    if (rif.recv_valid) n_valid++;
                    else n_err++;
                    if (rd_idx == wr_idx) begin
                        chk("unexpected_pulse", 1, 0);
                    end else begin
                        chk("pulse_kind_err", rif.frame_err, exp_arr[rd_idx].err);
                        chk($sformatf("pulse_time_off_%0d", cyc - exp_arr[rd_idx].due),
                            (cyc >= exp_arr[rd_idx].due - 1 && cyc <= exp_arr[rd_idx].due + 1), 1);
                        if (!exp_arr[rd_idx].err) model_last = exp_arr[rd_idx].data;
                        rd_idx++;
                    end
                end
                if (rd_idx != wr_idx && cyc > exp_arr[rd_idx].due + 1) begin
                    chk("missed_pulse", 0, 1);
                    rd_idx++;
                end
                chk("data_hold", rif.recv_data, model_last);
                if (!rif.recv_busy) begin
                    low_run++;
                end else begin
                    if (gap_track && low_run > max_gap) max_gap = low_run;
                    low_run = 0;
                end
            end
        end
    endtask

    initial begin
        int v0;
        int e0;
        int hi;
        fork
            compare_loop();
        join_none

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // 1: single nominal frame
        v0 = n_valid; e0 = n_err;
        send_frame(8'hA5, 1'b1, 0);
        idle(10);
        chk("t1_valid_count", n_valid - v0, 1);
        chk("t1_err_count", n_err - e0, 0);
        chk("t1_data", rif.recv_data, 8'hA5);

        // 2: back-to-back frames, no idle gap
        v0 = n_valid;
        low_run = 0; max_gap = 0; gap_track = 1'b1;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h55, 1'b1, 0);
        gap_track = 1'b0;
        idle(10);
        chk("t2_valid_count", n_valid - v0, 3);
        chk("t2_data_last", rif.recv_data, 8'h55);
        chk($sformatf("t2_gap_%0d_le6", max_gap), (max_gap >= 1 && max_gap <= 6), 1);

        // 3: 3-clock low glitch on an idle line
        v0 = n_valid; e0 = n_err; hi = 0;
        for (int i = 0; i < 25; i++) begin
            pin = (i < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rif.recv_busy) hi++;
        end
        chk($sformatf("t3_glitch_busy_%0d", hi), (hi >= 1 && hi <= 8), 1);
        chk("t3_no_pulse", (n_valid - v0) + (n_err - e0), 0);

        // 4: good frame, then bad stop bit followed by a held-low break
        v0 = n_valid; e0 = n_err;
        send_frame(8'h12, 1'b1, 0);
        send_frame(8'h3C, 1'b0, 0);
        hi = 0;
        pin = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rif.recv_busy) hi++;
        end
        pin = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rif.recv_busy) hi++;
        end
        chk("t4_valid_count", n_valid - v0, 1);
        chk("t4_err_count", n_err - e0, 1);
        chk("t4_data_kept", rif.recv_data, 8'h12);
        chk("t4_break_busy", hi, 0);

        // 5: reset during data bit 3 of 0xFA (bits 3..7 high, so no stray edges)
        v0 = n_valid; e0 = n_err;
        pin = 1'b0; repeat (10) @(negedge clk);
        pin = 1'b0; repeat (10) @(negedge clk);
        pin = 1'b1; repeat (10) @(negedge clk);
        pin = 1'b0; repeat (10) @(negedge clk);
        pin = 1'b1; repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(60);
        chk("t5_no_pulse", (n_valid - v0) + (n_err - e0), 0);
        chk("t5_data_reset", rif.recv_data, 8'h00);
        send_frame(8'h81, 1'b1, 0);
        idle(10);
        chk("t5_data_81", rif.recv_data, 8'h81);

        // 6: +-4% bit period
        e0 = n_err;
        send_frame(8'hC3, 1'b1, 1);
        idle(10);
        chk("t6_slow_data", rif.recv_data, 8'hC3);
        send_frame(8'hC3 ^ 8'hFF, 1'b1, 2);
        idle(10);
        chk("t6_fast_data", rif.recv_data, 8'h3C);
        chk("t6_no_err", n_err - e0, 0);

        // randomized frames: data, stop bit, rate skew and idle gap
        for (int k = 0; k < 30; k++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0),
                       int'($urandom_range(0, 2)));
            idle(int'($urandom_range(3, 8)));
        end
        idle(20);
        chk("pending_expect", wr_idx - rd_idx, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
